// File: rtl/tlc_pkg.sv
// rtl/tlc_pkg.sv - shared lamp encodings, state and group types for the phase scheduler (TLC_PED_EN adds WALK)
package tlc_pkg;

    localparam logic [1:0] LIGHT_GREEN  = 2'd0;
    localparam logic [1:0] LIGHT_YELLOW = 2'd1;
    localparam logic [1:0] LIGHT_RED    = 2'd2;

    typedef enum logic [1:0] {
        S_GREEN  = 2'd0,
        S_YELLOW = 2'd1,
        S_ALLRED = 2'd2
`ifdef TLC_PED_EN
        ,
        S_WALK   = 2'd3
`endif
    } tlc_state_t;

    typedef logic [1:0] group_t;

    localparam group_t GRP0 = 2'd0;
    localparam group_t GRP1 = 2'd1;
    localparam group_t GRP2 = 2'd2;

endpackage

// File: rtl/tlc_down_timer.sv
// rtl/tlc_down_timer.sv - loadable down-counter that parks at zero and flags it
module tlc_down_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/tlc_phase_scheduler.sv
// rtl/tlc_phase_scheduler.sv - three-group junction phase sequencer; TLC_PED_EN adds a pedestrian WALK phase
module tlc_phase_scheduler
    import tlc_pkg::*;
#(
    parameter int CNT_W   = 8,
    parameter int G_LONG  = 32,
    parameter int G_SHORT = 16,
    parameter int G_MIN   = 8,
    parameter int Y_T     = 4,
    parameter int AR_T    = 4
`ifdef TLC_PED_EN
    ,
    parameter int WALK_T  = 12
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       peak,
    input  logic [2:0] req,
`ifdef TLC_PED_EN
    input  logic       ped_req,
    output logic       ped_walk,
`endif
    output logic [1:0] light0,
    output logic [1:0] light1,
    output logic [1:0] light2,
    output logic [1:0] phase_id,
    output logic       phase_done
);

    localparam logic [CNT_W-1:0] GL_M1 = CNT_W'(G_LONG - 1);
    localparam logic [CNT_W-1:0] GS_M1 = CNT_W'(G_SHORT - 1);
    localparam logic [CNT_W-1:0] GM_M1 = CNT_W'(G_MIN - 1);
    localparam logic [CNT_W-1:0] Y_M1  = CNT_W'(Y_T - 1);
    localparam logic [CNT_W-1:0] AR_M1 = CNT_W'(AR_T - 1);
`ifdef TLC_PED_EN
    localparam logic [CNT_W-1:0] W_M1  = CNT_W'(WALK_T - 1);
`endif

    tlc_state_t       state, state_nx;
    group_t           phase_nx, next_grp;
    logic [2:1]       pend, pend_clr;
    logic             enter_green;
    logic             tmr_load, tmr_zero;
    logic [CNT_W-1:0] tmr_val;
    logic [2:0]       elig;
`ifdef TLC_PED_EN
    logic             ped_pend, walk_enter;
`endif

    function automatic logic [CNT_W-1:0] green_m1(group_t g, logic pk);
        if (g == GRP2) return pk ? GS_M1 : GM_M1;
        return pk ? GL_M1 : GS_M1;
    endfunction

    function automatic group_t grp_inc(group_t g);
        return (g == GRP2) ? GRP0 : g + 2'd1;
    endfunction

    function automatic logic [1:0] lamp(tlc_state_t st, group_t cur, group_t g);
        logic [1:0] l;
        l = LIGHT_RED;
        if (cur == g) begin
            case (st)
                S_GREEN:  l = LIGHT_GREEN;
                S_YELLOW: l = LIGHT_YELLOW;
                default:  l = LIGHT_RED;
            endcase
        end
        return l;
    endfunction

    // Round-robin search after the current owner; group 0 always qualifies so two steps suffice.
    always_comb begin
        elig     = {peak | pend[2], peak | pend[1], 1'b1};
        next_grp = phase_id;
        if (elig[grp_inc(phase_id)]) begin
            next_grp = grp_inc(phase_id);
        end else if (elig[grp_inc(grp_inc(phase_id))]) begin
            next_grp = grp_inc(grp_inc(phase_id));
        end
    end

    always_comb begin
        state_nx    = state;
        phase_nx    = phase_id;
        tmr_load    = 1'b0;
        tmr_val     = '0;
        enter_green = 1'b0;
`ifdef TLC_PED_EN
        walk_enter  = 1'b0;
`endif
        if (tmr_zero) begin
            case (state)
                S_GREEN: begin
                    tmr_load = 1'b1;
                    if (phase_id == GRP0 && !peak && pend == 2'b00) begin
                        tmr_val = green_m1(GRP0, peak);
                    end else begin
                        state_nx = S_YELLOW;
                        tmr_val  = Y_M1;
                    end
                end
                S_YELLOW: begin
                    state_nx = S_ALLRED;
                    tmr_load = 1'b1;
                    tmr_val  = AR_M1;
                end
                default: begin
                    tmr_load = 1'b1;
`ifdef TLC_PED_EN
                    if (state == S_ALLRED && ped_pend) begin
                        state_nx   = S_WALK;
                        tmr_val    = W_M1;
                        walk_enter = 1'b1;
                    end else
`endif
                    begin
                        state_nx    = S_GREEN;
                        phase_nx    = next_grp;
                        tmr_val     = green_m1(next_grp, peak);
                        enter_green = 1'b1;
                    end
                end
            endcase
        end
        if (reset) begin
            tmr_load = 1'b1;
            tmr_val  = green_m1(GRP0, peak);
        end
        pend_clr = enter_green ? {phase_nx == GRP2, phase_nx == GRP1} : 2'b00;
    end

    tlc_down_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    // Lamps are computed from the next state so they switch on the same edge as the FSM.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_GREEN;
            phase_id   <= GRP0;
            pend       <= 2'b00;
            phase_done <= 1'b0;
            light0     <= LIGHT_GREEN;
            light1     <= LIGHT_RED;
            light2     <= LIGHT_RED;
        end else begin
            state      <= state_nx;
            phase_id   <= phase_nx;
            pend       <= req[2:1] | (pend & ~pend_clr);
            phase_done <= enter_green;
            light0     <= lamp(state_nx, phase_nx, GRP0);
            light1     <= lamp(state_nx, phase_nx, GRP1);
            light2     <= lamp(state_nx, phase_nx, GRP2);
        end
    end

`ifdef TLC_PED_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            ped_pend <= 1'b0;
            ped_walk <= 1'b0;
        end else begin
            ped_pend <= ped_req | (ped_pend & ~walk_enter);
            ped_walk <= (state_nx == S_WALK);
        end
    end
`endif

endmodule

// File: tb/tb_tlc_phase_scheduler.sv
// tb/tb_tlc_phase_scheduler.sv - directed self-checking bench for the phase scheduler (TLC_PED_EN aware)
module tb_tlc_phase_scheduler;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       peak = 1'b0;
    logic [2:0] req = 3'b000;
    logic [1:0] light0, light1, light2, phase_id;
    logic       phase_done;
`ifdef TLC_PED_EN
    logic       ped_req = 1'b0;
    logic       ped_walk;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tlc_phase_scheduler dut (
        .clk        (clk),
        .reset      (reset),
        .peak       (peak),
        .req        (req),
`ifdef TLC_PED_EN
        .ped_req    (ped_req),
        .ped_walk   (ped_walk),
`endif
        .light0     (light0),
        .light1     (light1),
        .light2     (light2),
        .phase_id   (phase_id),
        .phase_done (phase_done)
    );

    // st: 0 green, 1 yellow, 2 all-red, 3 walk
    function automatic logic [1:0] exp_light(int grp, int st, int g);
        if (grp == g && st < 3) return 2'(st);
        return 2'd2;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic pk, input logic [2:0] rq);
        reset = 1'b1;
        peak  = pk;
        req   = rq;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset(1'b0, 3'b000);
        checks++; if (light0 !== 2'd0) begin errors++; $display("FAIL reset_light0 got %0d exp 0", light0); end
        checks++; if (light1 !== 2'd2) begin errors++; $display("FAIL reset_light1 got %0d exp 2", light1); end
        checks++; if (light2 !== 2'd2) begin errors++; $display("FAIL reset_light2 got %0d exp 2", light2); end
        checks++; if (phase_id !== 2'd0) begin errors++; $display("FAIL reset_phase_id got %0d exp 0", phase_id); end
        checks++; if (phase_done !== 1'b0) begin errors++; $display("FAIL reset_phase_done got %0d exp 0", phase_done); end
    endtask

    task automatic test_offpeak_requests();
        int sg[7] = '{0, 0, 0, 1, 1, 1, 2};
        int ss[7] = '{0, 1, 2, 0, 1, 2, 0};
        int sl[7] = '{16, 4, 4, 16, 4, 4, 8};
        int sp[7] = '{0, 0, 0, 1, 0, 0, 1};
        logic [8:0] got, exp;
        do_reset(1'b0, 3'b110);
        for (int s = 0; s < 7; s++) begin
            for (int k = 0; k < sl[s]; k++) begin
                got = {light0, light1, light2, phase_id, phase_done};
                exp = {exp_light(sg[s], ss[s], 0), exp_light(sg[s], ss[s], 1), exp_light(sg[s], ss[s], 2),
                       2'(sg[s]), (k == 0 && sp[s] == 1)};
                checks++;
                if (got !== exp) begin
                    errors++;
                    $display("FAIL offpeak_seq seg %0d cyc %0d got %h exp %h", s, k, got, exp);
                end
                tick();
            end
        end
        // group 2 is left pending by the held request; confirm it still times out after 8
        checks++;
        if (light2 !== 2'd1) begin errors++; $display("FAIL offpeak_g2_len got %0d exp 1", light2); end
    endtask

    task automatic test_idle_hold();
        int sg[7] = '{0, 0, 0, 2, 2, 2, 0};
        int ss[7] = '{0, 1, 2, 0, 1, 2, 0};
        int sl[7] = '{4, 4, 4, 8, 4, 4, 1};
        int sp[7] = '{0, 0, 0, 1, 0, 0, 1};
        logic [8:0] got, exp;
        do_reset(1'b0, 3'b000);
        for (int c = 0; c < 60; c++) begin
            got = {light0, light1, light2, phase_id, phase_done};
            checks++;
            if (got !== {2'd0, 2'd2, 2'd2, 2'd0, 1'b0}) begin
                errors++;
                $display("FAIL idle_hold cyc %0d got %h exp %h", c, got, {2'd0, 2'd2, 2'd2, 2'd0, 1'b0});
            end
            tick();
        end
        req = 3'b100;
        for (int s = 0; s < 7; s++) begin
            for (int k = 0; k < sl[s]; k++) begin
                got = {light0, light1, light2, phase_id, phase_done};
                exp = {exp_light(sg[s], ss[s], 0), exp_light(sg[s], ss[s], 1), exp_light(sg[s], ss[s], 2),
                       2'(sg[s]), (k == 0 && sp[s] == 1)};
                checks++;
                if (got !== exp) begin
                    errors++;
                    $display("FAIL idle_req2 seg %0d cyc %0d got %h exp %h", s, k, got, exp);
                end
                tick();
                req = 3'b000;
            end
        end
    endtask

    task automatic test_peak_cycle();
        int sg[10] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 0};
        int ss[10] = '{0, 1, 2, 0, 1, 2, 0, 1, 2, 0};
        int sl[10] = '{32, 4, 4, 32, 4, 4, 16, 4, 4, 1};
        int sp[10] = '{0, 0, 0, 1, 0, 0, 1, 0, 0, 1};
        logic [8:0] got, exp;
        do_reset(1'b1, 3'b000);
        for (int s = 0; s < 10; s++) begin
            for (int k = 0; k < sl[s]; k++) begin
                got = {light0, light1, light2, phase_id, phase_done};
                exp = {exp_light(sg[s], ss[s], 0), exp_light(sg[s], ss[s], 1), exp_light(sg[s], ss[s], 2),
                       2'(sg[s]), (k == 0 && sp[s] == 1)};
                checks++;
                if (got !== exp) begin
                    errors++;
                    $display("FAIL peak_seq seg %0d cyc %0d got %h exp %h", s, k, got, exp);
                end
                tick();
            end
        end
    endtask

    task automatic test_mid_reset();
        int sg[5] = '{0, 0, 0, 1, 1};
        int ss[5] = '{0, 1, 2, 0, 1};
        int sl[5] = '{16, 4, 4, 16, 2};
        int sp[5] = '{0, 0, 0, 1, 0};
        logic [8:0] got, exp;
        do_reset(1'b0, 3'b110);
        for (int s = 0; s < 5; s++) begin
            for (int k = 0; k < sl[s]; k++) begin
                got = {light0, light1, light2, phase_id, phase_done};
                exp = {exp_light(sg[s], ss[s], 0), exp_light(sg[s], ss[s], 1), exp_light(sg[s], ss[s], 2),
                       2'(sg[s]), (k == 0 && sp[s] == 1)};
                checks++;
                if (got !== exp) begin
                    errors++;
                    $display("FAIL midreset_pre seg %0d cyc %0d got %h exp %h", s, k, got, exp);
                end
                tick();
            end
        end
        do_reset(1'b0, 3'b000);
        // latches were cleared, so group 0 must hold green past its 16-cycle timer
        for (int c = 0; c < 24; c++) begin
            got = {light0, light1, light2, phase_id, phase_done};
            checks++;
            if (got !== {2'd0, 2'd2, 2'd2, 2'd0, 1'b0}) begin
                errors++;
                $display("FAIL midreset_post cyc %0d got %h exp %h", c, got, {2'd0, 2'd2, 2'd2, 2'd0, 1'b0});
            end
            tick();
        end
    endtask

    task automatic test_peak_toggle();
        int sg[5] = '{0, 0, 0, 1, 1};
        int ss[5] = '{0, 1, 2, 0, 1};
        int sl[5] = '{16, 4, 4, 32, 1};
        int sp[5] = '{0, 0, 0, 1, 0};
        logic [8:0] got, exp;
        int c;
        do_reset(1'b0, 3'b110);
        c = 0;
        for (int s = 0; s < 5; s++) begin
            for (int k = 0; k < sl[s]; k++) begin
                if (c == 5) peak = 1'b1;
                got = {light0, light1, light2, phase_id, phase_done};
                exp = {exp_light(sg[s], ss[s], 0), exp_light(sg[s], ss[s], 1), exp_light(sg[s], ss[s], 2),
                       2'(sg[s]), (k == 0 && sp[s] == 1)};
                checks++;
                if (got !== exp) begin
                    errors++;
                    $display("FAIL peak_toggle seg %0d cyc %0d got %h exp %h", s, k, got, exp);
                end
                tick();
                c++;
            end
        end
        peak = 1'b0;
    endtask

`ifdef TLC_PED_EN
    task automatic test_ped_walk();
        int sg[8] = '{0, 0, 0, 1, 1, 1, 1, 2};
        int ss[8] = '{0, 1, 2, 0, 1, 2, 3, 0};
        int sl[8] = '{16, 4, 4, 16, 4, 4, 12, 8};
        int sp[8] = '{0, 0, 0, 1, 0, 0, 0, 1};
        logic [9:0] got, exp;
        int c;
        do_reset(1'b0, 3'b110);
        checks++;
        if (ped_walk !== 1'b0) begin errors++; $display("FAIL ped_reset got %0d exp 0", ped_walk); end
        c = 0;
        for (int s = 0; s < 8; s++) begin
            for (int k = 0; k < sl[s]; k++) begin
                ped_req = (c == 30);
                got = {light0, light1, light2, phase_id, phase_done, ped_walk};
                exp = {exp_light(sg[s], ss[s], 0), exp_light(sg[s], ss[s], 1), exp_light(sg[s], ss[s], 2),
                       2'(sg[s]), (k == 0 && sp[s] == 1), (ss[s] == 3)};
                checks++;
                if (got !== exp) begin
                    errors++;
                    $display("FAIL ped_seq seg %0d cyc %0d got %h exp %h", s, k, got, exp);
                end
                tick();
                c++;
            end
        end
        ped_req = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_offpeak_requests();
        test_idle_hold();
        test_peak_cycle();
        test_mid_reset();
        test_peak_toggle();
`ifdef TLC_PED_EN
        test_ped_walk();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
